// File: rtl/ravan_pkg.sv
// Shared types and round arithmetic for the RAVAN iterative crypt engine.
// Round functions take an explicit width so one definition serves any DATA_W below MAX_W.
package ravan_pkg;

    localparam int MAX_W = 1024;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic word_t width_mask(input int w);
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t rotl(input word_t x, input int r, input int w);
        return ((x << r) | (x >> (w - r))) & width_mask(w);
    endfunction

    function automatic word_t rotr(input word_t x, input int r, input int w);
        return ((x >> r) | (x << (w - r))) & width_mask(w);
    endfunction

    function automatic word_t enc_round(input word_t s, input word_t k, input int r, input int w);
        return rotl(((s ^ k) + k) & width_mask(w), r, w);
    endfunction

    // Exact inverse of enc_round for the same subkey.
    function automatic word_t dec_round(input word_t s, input word_t k, input int r, input int w);
        return ((rotr(s, r, w) - k) ^ k) & width_mask(w);
    endfunction

endpackage

// File: rtl/ravan_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides, first-word fall-through read and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ravan_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_wready = (r_count != (AW+1)'(DEPTH));
    assign o_rvalid = (r_count != '0);
    assign o_rdata  = r_mem[r_rptr];
    assign o_count  = r_count;
    assign w_push   = i_wvalid && o_wready;
    assign w_pop    = o_rvalid && i_rready;

    // NOTE: the storage array has no reset; only pointers and count do, which lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ravan_iter_crypt_engine.sv
// Iterative RAVAN encrypt/decrypt engine: one round per clock, results buffered in an output FIFO.
// Optional block counter enabled by defining RAVAN_STATS_EN.
module ravan_iter_crypt_engine
    import ravan_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int KEY_W      = 512,
    parameter int ROUNDS     = 8,
    parameter int ROT        = 13,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [KEY_W-1:0]  key,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_enc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
`ifdef RAVAN_STATS_EN
   ,output logic [31:0]       blk_count
`endif
);

    localparam int NW    = KEY_W / DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Reset asserts immediately but releases only after two clean edges.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [KEY_W-1:0]  r_key;
    logic              r_key_loaded;
    logic [DATA_W-1:0] r_data;
    logic [TAG_W-1:0]  r_tag;
    logic              r_enc;
    logic              r_err;
    logic [7:0]        r_round;

    logic              w_key_fire;
    logic              w_in_fire;
    logic              w_push;
    logic              w_fifo_wready;
    logic              w_fifo_rvalid;
    logic [CNT_W-1:0]  w_fifo_count;
    entry_t            w_push_entry;
    entry_t            w_head;
    int                w_round_idx;
    logic [DATA_W-1:0] w_subkey;
    logic [DATA_W-1:0] w_round_out;

    // Key has priority over a block request; a block is only taken when its FIFO slot is free.
    assign key_ready  = (r_state == IDLE);
    assign in_ready   = (r_state == IDLE) && (w_fifo_count < CNT_W'(FIFO_DEPTH)) && !key_valid;
    assign w_key_fire = key_valid && key_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_push     = (r_state == DONE) && w_fifo_wready;

    // Decrypt walks the subkey schedule backwards.
    always_comb begin
        w_round_idx = r_enc ? int'(r_round) : (ROUNDS - 1 - int'(r_round));
        w_subkey    = r_key[(w_round_idx % NW) * DATA_W +: DATA_W];
        w_round_out = r_enc ? DATA_W'(enc_round(word_t'(r_data), word_t'(w_subkey), ROT, DATA_W))
                            : DATA_W'(dec_round(word_t'(r_data), word_t'(w_subkey), ROT, DATA_W));
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_in_fire) w_state_nxt = r_key_loaded ? RUN : DONE;
            RUN:     if (r_round == 8'(ROUNDS - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key        <= '0;
            r_key_loaded <= 1'b0;
            r_data       <= '0;
            r_tag        <= '0;
            r_enc        <= 1'b0;
            r_err        <= 1'b0;
            r_round      <= '0;
        end else begin
            if (w_key_fire) begin
                r_key        <= key;
                r_key_loaded <= 1'b1;
            end
            if (w_in_fire) begin
                r_data  <= r_key_loaded ? in_data : '0;
                r_tag   <= in_tag;
                r_enc   <= in_enc;
                r_err   <= !r_key_loaded;
                r_round <= '0;
            end else if (r_state == RUN) begin
                r_data  <= w_round_out;
                r_round <= r_round + 8'd1;
            end
        end
    end

    assign w_push_entry = '{data: r_data, tag: r_tag, err: r_err};

    ravan_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (w_rst_n),
        .i_wvalid (r_state == DONE),
        .o_wready (w_fifo_wready),
        .i_wdata  (w_push_entry),
        .o_rvalid (w_fifo_rvalid),
        .i_rready (out_ready),
        .o_rdata  (w_head),
        .o_count  (w_fifo_count)
    );

    // Head fields are masked while empty so outputs read zero out of reset.
    assign out_valid = w_fifo_rvalid;
    assign out_data  = w_fifo_rvalid ? w_head.data : '0;
    assign out_tag   = w_fifo_rvalid ? w_head.tag  : '0;
    assign out_err   = w_fifo_rvalid ? w_head.err  : 1'b0;

`ifdef RAVAN_STATS_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_blk_count <= '0;
        end else if (w_push && !r_err && (r_blk_count != 32'hFFFF_FFFF)) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_ravan_iter_crypt_engine.sv
// Scoreboard bench for ravan_iter_crypt_engine (DATA_W=64, KEY_W=512, ROUNDS=4, ROT=13, FIFO_DEPTH=2).
// Stimulus pushes expected results; a negedge monitor pops and compares on every output handshake.
module tb_ravan_iter_crypt_engine;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 512;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_valid = 1'b0;
    logic              key_ready;
    logic [KEY_W-1:0]  key = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_enc = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
`ifdef RAVAN_STATS_EN
    logic [31:0]       blk_count;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ravan_iter_crypt_engine #(
        .DATA_W     (DATA_W),
        .KEY_W      (KEY_W),
        .ROUNDS     (4),
        .ROT        (13),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_enc    (in_enc),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
`ifdef RAVAN_STATS_EN
       ,.blk_count (blk_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference cipher written directly for 64-bit words, 4 rounds, rotate by 13.
    function automatic logic [63:0] m_enc(input logic [63:0] x, input logic [511:0] k);
        logic [63:0] s;
        logic [63:0] kk;
        s = x;
        for (int i = 0; i < 4; i++) begin
            kk = k[i*64 +: 64];
            s  = (s ^ kk) + kk;
            s  = {s[50:0], s[63:51]};
        end
        return s;
    endfunction

    function automatic logic [511:0] rand_key();
        logic [511:0] k;
        for (int i = 0; i < 16; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got data=%h tag=%h err=%b, required no output", out_data, out_tag, out_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", 64'(out_tag), 64'(e.tag));
                check("out_err", 64'(out_err), 64'(e.err));
            end
        end
    end

    // Tasks start and end at posedge+1; ready is sampled at negedge.
    task automatic send_key(input logic [511:0] k);
        int n = 0;
        key_valid = 1'b1;
        key       = k;
        @(negedge clk);
        while (!key_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL key_accept_timeout: key_ready=0 after %0d cycles, required 1", n);
            key_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic send_req(input logic enc, input logic [63:0] data, input logic [3:0] tag,
                            input logic push, input logic [63:0] e_data, input logic e_err);
        int n = 0;
        in_valid = 1'b1;
        in_enc   = enc;
        in_data  = data;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_accept_timeout: in_ready=0 after %0d cycles, required 1", n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb_q.push_back('{data: e_data, tag: tag, err: e_err});
        #1 in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (edge 1) until out_valid is seen.
    task automatic measure_latency(input string name, input int exp_lat);
        int edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check(name, 64'(edges), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] k1;
        logic [511:0] k2;
        logic [63:0]  x;
        logic [63:0]  c;
        logic [3:0]   t;
        logic         seen_ready;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_key_ready", 64'(key_ready), 64'd1);
`ifdef RAVAN_STATS_EN
        check("rst_blk_count", 64'(blk_count), 64'd0);
`endif
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // No key loaded: error result two edges after accept
        send_req(1'b1, 64'h5, 4'h7, 1'b1, 64'h0, 1'b1);
        measure_latency("err_latency", 2);

        // Zero key: only the rotations act, 1 -> bit 52
        send_key('0);
        send_req(1'b1, 64'h1, 4'h3, 1'b1, 64'h0010_0000_0000_0000, 1'b0);
        measure_latency("enc_latency", 6);
        wait_drain();

        // Pending key blocks input acceptance
        key_valid = 1'b1;
        key       = '0;
        @(negedge clk);
        check("in_ready_key_priority", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 key_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_key", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed keys, including a reload between blocks
        for (int i = 0; i < 8; i++) k1[i*64 +: 64] = 64'h0123_4567_89AB_CDEF ^ (64'(i) << 56);
        k2 = {8{64'hFFFF_FFFF_FFFF_FFFF}};
        send_key(k1);
        x = 64'hCAFE_F00D_1234_5678;
        c = m_enc(x, k1);
        send_req(1'b1, x, 4'hA, 1'b1, c, 1'b0);
        send_req(1'b0, c, 4'hB, 1'b1, x, 1'b0);
        send_key(k2);
        send_req(1'b1, x, 4'hC, 1'b1, m_enc(x, k2), 1'b0);
        send_req(1'b0, m_enc(x, k2), 4'hD, 1'b1, x, 1'b0);
        wait_drain();

        // Random round trips
        for (int i = 0; i < 1000; i++) begin
            k1 = rand_key();
            x  = {$urandom, $urandom};
            t  = 4'($urandom_range(0, 15));
            c  = m_enc(x, k1);
            send_key(k1);
            send_req(1'b1, x, t, 1'b1, c, 1'b0);
            send_req(1'b0, c, t ^ 4'hF, 1'b1, x, 1'b0);
        end
        wait_drain();

        // FIFO full back-pressure
        k1 = rand_key();
        send_key(k1);
        out_ready = 1'b0;
        send_req(1'b1, 64'h11, 4'h1, 1'b1, m_enc(64'h11, k1), 1'b0);
        send_req(1'b1, 64'h22, 4'h2, 1'b1, m_enc(64'h22, k1), 1'b0);
        in_valid   = 1'b1;
        in_enc     = 1'b1;
        in_data    = 64'h33;
        in_tag     = 4'h3;
        seen_ready = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready) seen_ready = 1'b1;
        end
        check("in_ready_full", 64'(seen_ready), 64'd0);
        check("out_valid_full", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        send_req(1'b1, 64'h33, 4'h3, 1'b1, m_enc(64'h33, k1), 1'b0);
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Reset during RUN discards the block and the key
        send_key(k1);
        send_req(1'b1, 64'hDEAD_BEEF, 4'h9, 1'b0, 64'h0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrun_no_output", 64'(out_valid), 64'd0);
        send_req(1'b1, 64'h5, 4'h7, 1'b1, 64'h0, 1'b1);
        wait_drain();

        // Three good blocks after the error block
        send_key(k1);
        for (int i = 0; i < 3; i++) begin
            x = 64'h1000 + 64'(i);
            send_req(1'b1, x, 4'(i), 1'b1, m_enc(x, k1), 1'b0);
        end
        wait_drain();
`ifdef RAVAN_STATS_EN
        check("blk_count", 64'(blk_count), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
